// File: rtl/simple_pkg.sv
// Shared SIMPLE CPU definitions: I/O opcodes and seven-segment types.
package simple_pkg;

   localparam logic [3:0] OP_IN  = 4'd12;
   localparam logic [3:0] OP_OUT = 4'd13;

   // Active-low segment vector, bit order {g,f,e,d,c,b,a}
   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex digit to active-low seven-segment decoder.
module hex_to_seg7
   import simple_pkg::*;
(
   input  logic [3:0] nib,
   output seg7_t      seg
);

   always_comb begin
      seg = SEG7_BLANK;
      unique case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG7_BLANK;
      endcase
   end

endmodule

// File: rtl/out_port_display.sv
// CPU output port: latches 16-bit writes and scans them onto a 4-digit 7-seg display.
// Optional leading-zero blanking is enabled by defining SEG7_BLANK_LZ_EN.
module out_port_display
   import simple_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int DIV_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        out_we,
   input  logic [15:0] out_data,
   output logic        out_ack,
   output logic [15:0] disp_val,
   output logic [3:0]  an,
   output seg7_t       seg,
   output logic        dp
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [15:0]      data_q;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       dig;

   logic [15:0]      data_next;
   logic [DIV_W-1:0] div_cnt_next;
   logic [1:0]       dig_next;
   logic             tick;
   logic [3:0]       nib;
   seg7_t            seg_dec;
   seg7_t            seg_next;
   logic             blank;

   assign dp = 1'b1;

   // Outputs are computed from next-state values so a write and a digit step
   // landing on the same edge both show up immediately.
   always_comb begin
      tick         = (div_cnt == DIV_LAST);
      div_cnt_next = tick ? '0 : div_cnt + 1'b1;
      dig_next     = tick ? dig + 2'd1 : dig;
      data_next    = out_we ? out_data : data_q;
      nib          = data_next[{dig_next, 2'b00} +: 4];
   end

   hex_to_seg7 u_dec (
      .nib (nib),
      .seg (seg_dec)
   );

   always_comb begin
      blank = 1'b0;
`ifdef SEG7_BLANK_LZ_EN
      unique case (dig_next)
         2'd3:    blank = (data_next[15:12] == 4'h0);
         2'd2:    blank = (data_next[15:8]  == 8'h00);
         2'd1:    blank = (data_next[15:4]  == 12'h000);
         default: blank = 1'b0;
      endcase
`endif
      seg_next = blank ? SEG7_BLANK : seg_dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         div_cnt  <= '0;
         dig      <= 2'd0;
         out_ack  <= 1'b0;
         disp_val <= 16'h0000;
         an       <= 4'b1110;
         seg      <= 7'h40;
      end else begin
         data_q   <= data_next;
         div_cnt  <= div_cnt_next;
         dig      <= dig_next;
         out_ack  <= out_we;
         disp_val <= data_next;
         an       <= ~(4'b0001 << dig_next);
         seg      <= seg_next;
      end
   end

endmodule

// File: doc/out_port_display.md
# out_port_display

Output-port unit for the 16-bit SIMPLE CPU, the write-direction counterpart to the ALU's dipswitch `in` path. On an `out` instruction, writeback strobes a 16-bit value into this block. The block latches the value and shows it as four hex digits on a time-multiplexed common-anode seven-segment display. It acknowledges each write and free-runs the digit scan from a programmable clock divider.

## Interface
Parameters:
- `DIV`, default 50000: `clk` cycles per digit slot, legal range ≥ 2.
- `DIV_W`, default 16: width of the divider counter. Must satisfy 2^DIV_W ≥ DIV.

Ports:
- `clk`, input, 1 bit: single clock. All state is updated on the rising edge.
- `rst_n`, input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `out_we`, input, 1 bit: write strobe from CPU writeback, sampled on each rising edge.
- `out_data`, input, 16 bits: value to display. Sampled when `out_we` = 1.
- `out_ack`, output, 1 bit: one-cycle pulse acknowledging a captured write.
- `disp_val`, output, 16 bits: the currently latched value, for debug and readback.
- `an`, output, 4 bits: digit enables, active-low. Bit i selects digit i; digit 0 is the least significant nibble.
- `seg`, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
- `dp`, output, 1 bit: decimal point, active-low. Held at 1 (off).

## Operation
- Data latch `data_q`:
  - On an edge with `out_we` = 1, `data_q` ← `out_data`.
  - Otherwise `data_q` holds.
  - A write on every cycle is legal; the last write wins.
- Acknowledge: `out_ack` is registered and equals the `out_we` sampled on the previous edge. Back-to-back writes therefore give back-to-back acks. There is no backpressure and the block is always ready.
- Divider `div_cnt`, DIV_W bits:
  - Counts 0 … DIV−1, then wraps to 0.
  - `tick` = (`div_cnt` == DIV−1).
- Digit index `dig`, 2 bits:
  - Advances on `tick` in the order 0→1→2→3→0.
  - Nibble for digit i is `data_q[4i+3:4i]`.
- Outputs:
  - `an`, `seg` and `disp_val` are registered.
  - Each cycle they are computed from the next-state `dig` and `data_q`.
  - `an` = ~(1 << dig_next).
  - `seg` = hex decode of the selected nibble.
- Hex decode, active-low, 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, bit 6 = g).
- Reset values:
  - `data_q` = 0, `div_cnt` = 0, `dig` = 0.
  - `out_ack` = 0, `disp_val` = 16'h0000.
  - `an` = 4'b1110, `seg` = 7'h40 (digit "0"), `dp` = 1.
- Reset mid-scan or mid-write: every register returns to its reset value immediately and asynchronously. A write pending on that edge is lost and produces no ack.

## Timing
- Write latency:
  - `out_we` sampled at edge N.
  - `disp_val` and the lit digit's `seg` reflect the new value from edge N.
  - `out_ack` = 1 for the cycle following edge N.
- Scan:
  - Each digit is lit for exactly DIV cycles.
  - A full frame is 4·DIV cycles.
  - The first `an` change after reset occurs at edge DIV.
- Simultaneous write and `tick`: the new data and the new digit both take effect on the same edge. `seg` shows the new digit of the new value.

## Configuration
- Macro `SEG7_BLANK_LZ_EN` (leading-zero blanking):
  - Defined: digits 3..1 that lie above the highest nonzero nibble of `data_q` drive `seg` = 7'h7F (all off). Digit 0 is never blanked, so a value of 0 shows "0". `an` continues to scan unchanged.
  - Undefined: all four digits are always shown, e.g. 0x002A displays "002A".

## Structure
- Shared package `simple_pkg`:
  - `OP_OUT` = 4'd13, alongside the existing `in` = 12.
  - Typedef `seg7_t` (7-bit active-low segment vector).
  - Constant `SEG7_BLANK` = 7'h7F.
- Sub-module `hex_to_seg7`: purely combinational 4-bit → `seg7_t` decoder, instantiated once, fed by the nibble mux.
- Everything else (latch, divider, scan, ack) lives in the top module.

## Test plan
All scenarios use DIV = 4.
1. Assert `rst_n` = 0 mid-run → immediately `an` = 1110, `seg` = 40, `out_ack` = 0, `disp_val` = 0000. After release, the first `an` change occurs at the 4th edge.
2. Write 16'h1234 once, then run 16 cycles → `seg` sequence 19, 30, 24, 79 with `an` = 1110, 1101, 1011, 0111, each held 4 cycles. `out_ack` is high exactly one cycle.
3. Writes on three consecutive cycles: 0xAAAA, 0xBBBB, 0xC0DE → `out_ack` high for three cycles. `disp_val` ends at C0DE, and digit 0 shows 06.
4. Write 0xF00F on the same edge that `tick` advances `dig` 0→1 → the next `seg` is 40, digit 1 of the new value.
5. With `SEG7_BLANK_LZ_EN` defined, write 0x002A → digits 3 and 2 show 7F, digits 1 and 0 show 24 and 08. Write 0x0000 → only digit 0 shows 40.
6. Assert reset in the same cycle as `out_we` = 1 with 0x5555 → the value is not captured, `disp_val` = 0000, and no ack pulse appears after release.
